alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (register count fixed at 32, index 5 bits).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  instruction offered.
REQ-005 SHALL have port: in_ready  output  1  instruction accepted this cycle when in_valid is also high.
REQ-006 SHALL have ports: in_op  input  3  ALUOp code; in_rs, in_rt, in_rd  input  5 each  source/destination register indices.
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1  handshake to downstream ALU.
REQ-008 SHALL have ports: out_a, out_b  output  DATA_W  operands A/B; out_op  output  3; out_rd  output  5.
REQ-009 SHALL have ports: wb_valid  input  1; wb_rd  input  5; wb_data  input  DATA_W  ALU result writeback.
REQ-010 SHALL have port: busy  output  32  scoreboard, bit i high = register i has a write pending.

Function
REQ-011 SHALL hold a 32 x DATA_W register file; register 0 reads 0 and ignores writes.
REQ-012 SHALL write wb_data to register wb_rd on every cycle wb_valid is high (wb_rd != 0), whether or not busy[wb_rd] is set.
REQ-013 SHALL clear busy[wb_rd] on wb_valid; busy[0] is never set.
REQ-014 SHALL flag hazard when rs, rt or rd (nonzero) has its busy bit set (RAW and WAW both stall).
REQ-015 SHALL drive in_ready = !hazard && (!out_valid || out_ready), combinationally.
REQ-016 SHALL on accept (in_valid && in_ready) load out_a = R[rs], out_b = R[rt], out_op, out_rd and set out_valid at the next edge: latency 1 cycle.
REQ-017 SHALL on accept set busy[rd] if rd != 0; same-cycle wb clear and issue set on the same index: set wins.
REQ-018 SHALL clear out_valid when out_ready is high and no new accept occurs; out_* hold stable while out_valid && !out_ready.
REQ-019 SHALL pass in_op codes 6 and 7 through unchanged (no decode, no error).
REQ-020 SHALL sustain one issue per cycle when no hazard and out_ready is held high.

Reset
REQ-021 SHALL on rst_n low at an edge zero all registers, busy, out_valid, out_a, out_b, out_op, out_rd; in_ready is 1 the cycle after reset deasserts.
REQ-022 SHALL discard any instruction held in the output register when reset is applied mid-operation; pending writebacks are forgotten.

Configuration
REQ-023 SHALL support macro GRF_BYPASS_EN: when defined, a same-cycle wb_valid to an index removes that index from hazard evaluation and wb_data is forwarded to out_a/out_b.
REQ-024 SHALL without GRF_BYPASS_EN evaluate hazard from registered busy only; the dependent instruction issues one cycle after writeback.

Structure
REQ-025 SHALL place ALUOp constants (ADD 0, SUB 1, AND 2, OR 3, SRL 4, SRA 5), REG_IDX_W = 5 and DATA_W default in shared package alu_pkg.
REQ-026 SHALL implement the register file as sub-module grf (2 async read ports, 1 sync write port); scoreboard and handshake stay in alu_issue_stage.

Verification
REQ-027 SHALL cover: reset, then wb R3=0x0000_0005; issue op 0 rs=3 rt=0 rd=4 -> next cycle out_valid=1, out_a=5, out_b=0, busy[4]=1.
REQ-028 SHALL cover: rd=4 pending, offer rs=4 -> in_ready=0 until wb rd=4 data 0xDEAD_BEEF; with GRF_BYPASS_EN issue same cycle, out_a=0xDEAD_BEEF; without, one cycle later.
REQ-029 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; out_ready=1 -> next instruction accepted that cycle.
REQ-030 SHALL cover: issue rd=0 and wb rd=0 data 0xFFFF_FFFF -> busy stays 0, subsequent read of R0 returns 0.
REQ-031 SHALL cover: wb rd=7 clearing busy[7] same cycle as new issue rd=7 -> busy[7]=1 after the edge.
REQ-032 SHALL cover: rst_n low while out_valid=1 and busy=0x0000_0010 -> next cycle out_valid=0, busy=0, all registers read 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, widths and index helpers for the issue stage
package alu_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int REG_IDX_W      = 5;
    localparam int NUM_REGS       = 32;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;

    // One-hot mask of a register index; R0 never maps to a bit so it can never be tracked.
    function automatic logic [NUM_REGS-1:0] idx_mask(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m      = '0;
        m[idx] = (idx != '0);
        return m;
    endfunction

endpackage

// File: rtl/grf.sv
// rtl/grf.sv - 32-entry general register file, 2 async read ports, 1 sync write port, R0 hardwired to 0
module grf
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] ra_idx,
    output logic [DATA_W-1:0]    ra_data,
    input  logic [REG_IDX_W-1:0] rb_idx,
    output logic [DATA_W-1:0]    rb_data,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_idx == '0) ? '0 : regs[ra_idx];
    assign rb_data = (rb_idx == '0) ? '0 : regs[rb_idx];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - scoreboarded ALU issue stage; GRF_BYPASS_EN enables same-cycle writeback forwarding
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [REG_IDX_W-1:0] in_rs,
    input  logic [REG_IDX_W-1:0] in_rt,
    input  logic [REG_IDX_W-1:0] in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_a,
    output logic [DATA_W-1:0]    out_b,
    output logic [2:0]           out_op,
    output logic [REG_IDX_W-1:0] out_rd,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [NUM_REGS-1:0]  busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] wb_mask;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic                hazard;
    logic                accept;

    grf #(.DATA_W(DATA_W)) u_grf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_idx  (in_rs),
        .ra_data (rs_data),
        .rb_idx  (in_rt),
        .rb_data (rt_data),
        .we      (wb_valid),
        .wa      (wb_rd),
        .wd      (wb_data)
    );

    assign wb_mask = wb_valid ? idx_mask(wb_rd) : '0;

`ifdef GRF_BYPASS_EN
    // A register being written back this cycle is already resolved; take the value off the wb bus.
    assign busy_eff = busy_q & ~wb_mask;
    assign a_sel    = wb_mask[in_rs] ? wb_data : rs_data;
    assign b_sel    = wb_mask[in_rt] ? wb_data : rt_data;
`else
    assign busy_eff = busy_q;
    assign a_sel    = rs_data;
    assign b_sel    = rt_data;
`endif

    // busy_q[0] is never set, so R0 operands and destinations never stall.
    assign hazard   = busy_eff[in_rs] | busy_eff[in_rt] | busy_eff[in_rd];
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Clear first, then set, so an issue to the index being written back keeps its pending bit.
    assign busy_nxt = (busy_q & ~wb_mask) | (accept ? idx_mask(in_rd) : '0);
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            out_rd    <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_a     <= a_sel;
                out_b     <= b_sel;
                out_op    <= in_op;
                out_rd    <= in_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op;
    logic [4:0]  out_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy;

    int checks = 0;
    int fails  = 0;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v; wb_rd = rd; wb_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0); set_wb(0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (out_a !== 32'h0 || out_b !== 32'h0) begin fails++; $display("FAIL reset_operands got %h/%h want 0/0", out_a, out_b); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_issue();
        tick();
        set_wb(1, 3, 32'h0000_0005);
        tick();
        set_wb(0, 0, 0);
        set_in(1, 0, 3, 0, 4);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL issue_in_ready got %b want 1", in_ready); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL issue_out_valid got %b want 1", out_valid); end
        checks++; if (out_a !== 32'h5) begin fails++; $display("FAIL issue_out_a got %h want 00000005", out_a); end
        checks++; if (out_b !== 32'h0) begin fails++; $display("FAIL issue_out_b got %h want 0", out_b); end
        checks++; if (out_rd !== 5'd4 || out_op !== 3'd0) begin fails++; $display("FAIL issue_rd_op got %0d/%0d want 4/0", out_rd, out_op); end
        checks++; if (busy !== 32'h10) begin fails++; $display("FAIL issue_busy got %h want 00000010", busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL issue_drain got %b want 0", out_valid); end
    endtask

    task automatic test_hazard();
        set_in(1, 1, 4, 3, 5);
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hazard_stall got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL hazard_hold got rdy=%b vld=%b want 0/0", in_ready, out_valid); end
        set_wb(1, 4, 32'hDEAD_BEEF);
        #1;
`ifdef GRF_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hazard_bypass_ready got %b want 1", in_ready); end
        tick();
        set_wb(0, 0, 0); set_in(0, 0, 0, 0, 0);
        #1;
`else
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hazard_wb_cycle_ready got %b want 0", in_ready); end
        tick();
        set_wb(0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 32'h0) begin fails++; $display("FAIL hazard_after_wb got rdy=%b busy=%h want 1/00000000", in_ready, busy); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
`endif
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hazard_out_valid got %b want 1", out_valid); end
        checks++; if (out_a !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hazard_out_a got %h want deadbeef", out_a); end
        checks++; if (out_b !== 32'h5 || out_op !== 3'd1) begin fails++; $display("FAIL hazard_out_b_op got %h/%0d want 00000005/1", out_b, out_op); end
        checks++; if (busy !== 32'h20) begin fails++; $display("FAIL hazard_busy got %h want 00000020", busy); end
        tick();
        set_wb(1, 5, 32'h11);
        tick();
        set_wb(0, 0, 0);
        #1;
        checks++; if (busy !== 32'h0 || out_valid !== 1'b0) begin fails++; $display("FAIL hazard_cleanup got busy=%h vld=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1, 2, 3, 4, 6);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
        tick();
        set_in(1, 3, 3, 0, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall[%0d] got rdy=%b vld=%b want 0/1", i, in_ready, out_valid); end
            checks++; if (out_a !== 32'h5 || out_b !== 32'hDEAD_BEEF || out_op !== 3'd2 || out_rd !== 5'd6) begin fails++; $display("FAIL bp_hold[%0d] got %h %h %0d %0d want 00000005 deadbeef 2 6", i, out_a, out_b, out_op, out_rd); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (out_op !== 3'd3 || out_rd !== 5'd8 || out_a !== 32'h5 || out_b !== 32'h0) begin fails++; $display("FAIL bp_next got %0d %0d %h %h want 3 8 00000005 00000000", out_op, out_rd, out_a, out_b); end
        checks++; if (busy !== 32'h140) begin fails++; $display("FAIL bp_busy got %h want 00000140", busy); end
        set_wb(1, 6, 32'h66);
        tick();
        set_wb(1, 8, 32'h88);
        tick();
        set_wb(0, 0, 0);
        #1;
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL bp_cleanup got %h want 0", busy); end
    endtask

    task automatic test_r0_and_ops();
        set_wb(1, 0, 32'hFFFF_FFFF);
        set_in(1, 6, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL r0_ready got %b want 1", in_ready); end
        tick();
        set_in(1, 7, 0, 0, 0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_op !== 3'd6 || busy !== 32'h0) begin fails++; $display("FAIL r0_op6 got vld=%b op=%0d busy=%h want 1/6/0", out_valid, out_op, busy); end
        tick();
        set_in(0, 0, 0, 0, 0); set_wb(0, 0, 0);
        #1;
        checks++; if (out_op !== 3'd7 || out_a !== 32'h0 || out_b !== 32'h0) begin fails++; $display("FAIL r0_read got op=%0d a=%h b=%h want 7/0/0", out_op, out_a, out_b); end
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL r0_busy got %h want 0", busy); end
        tick();
    endtask

    task automatic test_set_wins();
        set_wb(1, 7, 32'h77);
        set_in(1, 0, 0, 0, 7);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL setwins_ready got %b want 1", in_ready); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (busy !== 32'h80) begin fails++; $display("FAIL setwins_busy got %h want 00000080", busy); end
        tick();
        set_wb(0, 0, 0);
        #1;
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL setwins_clear got %h want 0", busy); end
    endtask

    task automatic test_back_to_back();
        set_in(1, 4, 7, 3, 9);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_first_ready got %b want 1", in_ready); end
        tick();
        set_in(1, 5, 3, 7, 10);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_second_ready got %b want 1", in_ready); end
        checks++; if (out_a !== 32'h77 || out_b !== 32'h5 || out_op !== 3'd4 || out_rd !== 5'd9) begin fails++; $display("FAIL b2b_first got %h %h %0d %0d want 00000077 00000005 4 9", out_a, out_b, out_op, out_rd); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (out_a !== 32'h5 || out_b !== 32'h77 || out_op !== 3'd5 || out_rd !== 5'd10) begin fails++; $display("FAIL b2b_second got %h %h %0d %0d want 00000005 00000077 5 10", out_a, out_b, out_op, out_rd); end
        checks++; if (busy !== 32'h600) begin fails++; $display("FAIL b2b_busy got %h want 00000600", busy); end
    endtask

    task automatic test_reset_mid();
        set_wb(1, 9, 32'h0);
        tick();
        set_wb(1, 10, 32'h0);
        tick();
        set_wb(0, 0, 0);
        out_ready = 1'b0;
        set_in(1, 0, 3, 0, 4);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (out_valid !== 1'b1 || busy !== 32'h10) begin fails++; $display("FAIL rstmid_pre got vld=%b busy=%h want 1/00000010", out_valid, busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 32'h0) begin fails++; $display("FAIL rstmid_state got vld=%b busy=%h want 0/0", out_valid, busy); end
        checks++; if (out_a !== 32'h0 || out_op !== 3'd0 || out_rd !== 5'd0) begin fails++; $display("FAIL rstmid_out got a=%h op=%0d rd=%0d want 0/0/0", out_a, out_op, out_rd); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        set_in(1, 0, 3, 7, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_a !== 32'h0 || out_b !== 32'h0) begin fails++; $display("FAIL rstmid_regs got vld=%b a=%h b=%h want 1/0/0", out_valid, out_a, out_b); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_hazard();
        test_backpressure();
        test_r0_and_ops();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
